// File: rtl/polar_pkg.sv
// Shared polar-code configuration: code length, info-bit count, default frozen set
// and the extractor's output-register state encoding.
package polar_pkg;

    localparam int N_DEF = 8;
    localparam int K_DEF = 4;
    localparam int IDX_W_DEF = $clog2(N_DEF);
    localparam int OUT_WIDTH_DEF = 8;
    // Info positions {3,5,6,7}; a set bit marks a frozen index.
    localparam logic [N_DEF-1:0] FROZEN_MASK_DEF = 8'b0001_0111;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    function automatic int info_count(input logic [63:0] mask, input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            if (!mask[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/polar_info_extractor.sv
// Drops frozen positions from the SC decoder's hard-decision stream and packs the
// information bits LSB-first into valid/ready output words.
module polar_info_extractor
    import polar_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int K = K_DEF,
    parameter logic [N-1:0] FROZEN_MASK = N'(FROZEN_MASK_DEF),
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 u_valid,
    input  logic                 u_bit,
    output logic                 u_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 frame_done,
    output logic                 frozen_err
);

    localparam int IW = $clog2(N);
    localparam int PW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
    localparam logic [PW-1:0] PACK_LAST = PW'(OUT_WIDTH - 1);
    localparam logic [CW-1:0] INFO_LAST = CW'(K - 1);

    generate
        if (K < 1 || K != info_count(64'(FROZEN_MASK), N)) begin : g_bad_cfg
            $error("polar_info_extractor: K must be >= 1 and equal the number of info positions");
        end
    endgenerate

    logic [IW-1:0]        idx;
    logic [PW-1:0]        pack_cnt;
    logic [CW-1:0]        info_cnt;
    logic [OUT_WIDTH-1:0] shreg;
    logic [OUT_WIDTH-1:0] packed_word;
    logic                 is_info;
    logic                 is_k_th;
    logic                 completing;
    logic                 accept;
    logic                 load;
    state_t               state;
    state_t               state_next;

    assign is_info    = ~FROZEN_MASK[idx];
    assign is_k_th    = (info_cnt == INFO_LAST);
    assign completing = is_info & ((pack_cnt == PACK_LAST) | is_k_th);
    // Only a word-completing bit can stall, and only when the single output slot stays occupied.
    assign u_ready    = ~completing | (state == EMPTY) | out_ready;
    assign accept     = u_valid & u_ready;
    assign load       = accept & completing;
    assign out_valid  = (state == FULL);

    // Shift register image with the incoming bit merged at its packing slot.
    always_comb begin
        packed_word = shreg;
        packed_word[pack_cnt] = u_bit;
    end

    // Frame index, packing position and info-bit counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            pack_cnt <= '0;
            info_cnt <= '0;
            shreg    <= '0;
        end else if (accept) begin
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            if (is_info) begin
                info_cnt <= is_k_th ? '0 : info_cnt + CW'(1);
                if (completing) begin
                    pack_cnt <= '0;
                    shreg    <= '0;
                end else begin
                    pack_cnt <= pack_cnt + PW'(1);
                    shreg    <= packed_word;
                end
            end
        end
    end

    // Output word register and frame status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            frozen_err <= 1'b0;
        end else begin
            frame_done <= accept & (idx == IDX_LAST);
            frozen_err <= frozen_err | (accept & ~is_info & u_bit);
            if (load) begin
                out_data <= packed_word;
                out_last <= is_k_th;
            end
        end
    end

    // Output slot occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A load while FULL only happens alongside a drain, so the new word simply replaces it.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (load) state_next = FULL;
                else      state_next = EMPTY;
            end
            FULL: begin
                if (load)           state_next = FULL;
                else if (out_ready) state_next = EMPTY;
                else                state_next = FULL;
            end
            default: state_next = EMPTY;
        endcase
    end

endmodule

// File: tb/tb_polar_info_extractor.sv
// Bench for polar_info_extractor: an 8-bit-word and a 2-bit-word instance driven
// from a frame table, with queued expected words checked as the DUTs emit them.
module tb_polar_info_extractor;

    localparam logic [7:0] MASK = 8'b0001_0111;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } word_t;

    typedef struct {
        logic [7:0] u;
        logic [7:0] exp8;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       u_valid [2];
    logic       u_bit [2];
    logic       out_ready [2];
    logic       u_ready [2];
    logic       out_valid [2];
    logic       out_last [2];
    logic       frame_done [2];
    logic       frozen_err [2];
    logic [7:0] out_data0;
    logic [1:0] out_data1;

    int    total;
    int    bad;
    int    cyc;
    int    fd_cnt [2];
    int    fd_last [2];
    int    fd_gap_bad [2];
    word_t q0[$];
    word_t q1[$];
    vec_t  tbl [6];

    polar_info_extractor #(.OUT_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .u_valid(u_valid[0]), .u_bit(u_bit[0]), .u_ready(u_ready[0]),
        .out_data(out_data0), .out_valid(out_valid[0]), .out_last(out_last[0]),
        .out_ready(out_ready[0]), .frame_done(frame_done[0]), .frozen_err(frozen_err[0])
    );

    polar_info_extractor #(.OUT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .u_valid(u_valid[1]), .u_bit(u_bit[1]), .u_ready(u_ready[1]),
        .out_data(out_data1), .out_valid(out_valid[1]), .out_last(out_last[1]),
        .out_ready(out_ready[1]), .frame_done(frame_done[1]), .frozen_err(frozen_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on every output handshake, log frame_done pulses.
    always @(negedge clk) begin
        word_t w;
        #2;
        if (out_valid[0] && out_ready[0]) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL w8 unexpected word: got %0h, expected none", out_data0);
            end else begin
                w = q0.pop_front();
                chk("w8 data", 32'(out_data0), 32'(w.data));
                chk("w8 last", 32'(out_last[0]), 32'(w.last));
            end
        end
        if (out_valid[1] && out_ready[1]) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL w2 unexpected word: got %0h, expected none", out_data1);
            end else begin
                w = q1.pop_front();
                chk("w2 data", 32'(out_data1), 32'(w.data));
                chk("w2 last", 32'(out_last[1]), 32'(w.last));
            end
        end
        for (int s = 0; s < 2; s++) begin
            if (frame_done[s]) begin
                if (fd_cnt[s] > 0 && (cyc - fd_last[s]) != 8) fd_gap_bad[s]++;
                fd_last[s] = cyc;
                fd_cnt[s]++;
            end
        end
    end

    // Independent model of the 2-bit packing: info bits in index order, pairs LSB-first.
    function automatic void push_model2(input logic [7:0] u);
        int k;
        logic [1:0] acc;
        word_t w;
        k = 0;
        acc = 2'b00;
        for (int i = 0; i < 8; i++) begin
            if (!MASK[i]) begin
                acc[k % 2] = u[i];
                if ((k % 2) == 1 || k == 3) begin
                    w.data = {6'd0, acc};
                    w.last = (k == 3);
                    q1.push_back(w);
                    acc = 2'b00;
                end
                k++;
            end
        end
    endfunction

    task automatic send_bit(input int sel, input logic b, output int tries);
        @(negedge clk);
        u_valid[sel] = 1'b1;
        u_bit[sel] = b;
        #1;
        tries = 0;
        while (!u_ready[sel] && tries < 40) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!u_ready[sel]) begin
            total++; bad++;
            $display("FAIL u_ready timeout: got 0, expected 1 on dut %0d", sel);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] u, input logic [7:0] exp8,
                              output logic [7:0] stall_mask);
        int t;
        word_t w;
        if (sel == 0) begin
            w.data = exp8;
            w.last = 1'b1;
            q0.push_back(w);
        end else begin
            push_model2(u);
        end
        stall_mask = 8'h00;
        for (int i = 0; i < 8; i++) begin
            send_bit(sel, u[i], t);
            stall_mask[i] = (t != 0);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        u_valid[0] = 1'b0;
        u_valid[1] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("%s out_valid[%0d]", tag, s), 32'(out_valid[s]), 32'd0);
            chk($sformatf("%s out_last[%0d]", tag, s), 32'(out_last[s]), 32'd0);
            chk($sformatf("%s frame_done[%0d]", tag, s), 32'(frame_done[s]), 32'd0);
            chk($sformatf("%s frozen_err[%0d]", tag, s), 32'(frozen_err[s]), 32'd0);
            chk($sformatf("%s u_ready[%0d]", tag, s), 32'(u_ready[s]), 32'd1);
        end
        chk($sformatf("%s out_data w8", tag), 32'(out_data0), 32'd0);
        chk($sformatf("%s out_data w2", tag), 32'(out_data1), 32'd0);
    endtask

    initial begin
        logic [7:0] sm;
        logic [7:0] sm0;
        logic [7:0] sm1;
        int t;
        total = 0;
        bad = 0;
        cyc = 0;
        for (int s = 0; s < 2; s++) begin
            u_valid[s] = 1'b0;
            u_bit[s] = 1'b0;
            out_ready[s] = 1'b1;
            fd_cnt[s] = 0;
            fd_last[s] = 0;
            fd_gap_bad[s] = 0;
        end
        tbl[0] = '{u: 8'h68, exp8: 8'h07};
        tbl[1] = '{u: 8'hE8, exp8: 8'h0F};
        tbl[2] = '{u: 8'h00, exp8: 8'h00};
        tbl[3] = '{u: 8'h88, exp8: 8'h09};
        tbl[4] = '{u: 8'h20, exp8: 8'h02};
        tbl[5] = '{u: 8'h40, exp8: 8'h04};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Back-to-back frames from the table, u_valid held high throughout.
        for (int s = 0; s < 2; s++) begin
            fd_cnt[s] = 0;
            fd_gap_bad[s] = 0;
            for (int i = 0; i < 6; i++) begin
                send_frame(s, tbl[i].u, tbl[i].exp8, sm);
                chk($sformatf("b2b stall dut%0d frame%0d", s, i), 32'(sm), 32'd0);
            end
            idle(4);
            chk($sformatf("b2b frame_done count dut%0d", s), 32'(fd_cnt[s]), 32'd6);
            chk($sformatf("b2b frame_done spacing dut%0d", s), 32'(fd_gap_bad[s]), 32'd0);
            chk($sformatf("b2b frozen_err dut%0d", s), 32'(frozen_err[s]), 32'd0);
        end
        chk("b2b w8 words drained", 32'(q0.size()), 32'd0);
        chk("b2b w2 words drained", 32'(q1.size()), 32'd0);

        // Backpressure on the 2-bit instance: only the last info bit may stall.
        out_ready[1] = 1'b0;
        fork
            send_frame(1, 8'h68, 8'h00, sm);
            begin
                repeat (10) @(negedge clk);
                out_ready[1] = 1'b1;
            end
        join
        chk("stall position mask", 32'(sm), 32'h80);
        idle(4);
        chk("stall w2 words drained", 32'(q1.size()), 32'd0);

        // Frozen index 1 reported as 1: sticky error, data unaffected.
        begin
            word_t w;
            w.data = 8'h07;
            w.last = 1'b1;
            q0.push_back(w);
        end
        send_bit(0, 1'b0, t);
        chk("frozen_err before bad bit", 32'(frozen_err[0]), 32'd0);
        send_bit(0, 1'b1, t);
        chk("frozen_err after bad bit", 32'(frozen_err[0]), 32'd1);
        for (int i = 2; i < 8; i++) begin
            sm = 8'h6A;
            send_bit(0, sm[i], t);
        end
        send_frame(0, 8'h68, 8'h07, sm);
        idle(4);
        chk("frozen_err sticky across frames", 32'(frozen_err[0]), 32'd1);
        chk("frozen_err other dut", 32'(frozen_err[1]), 32'd0);
        chk("frozen w8 words drained", 32'(q0.size()), 32'd0);

        // Reset in the middle of a frame drops it; next bit starts a fresh frame.
        fork
            begin
                sm0 = 8'h68;
                for (int i = 0; i < 5; i++) send_bit(0, sm0[i], t);
            end
            begin
                sm1 = 8'h68;
                for (int i = 0; i < 5; i++) send_bit(1, sm1[i], t);
            end
        join
        @(negedge clk);
        u_valid[0] = 1'b0;
        u_valid[1] = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_values("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fork
            send_frame(0, 8'h68, 8'h07, sm0);
            send_frame(1, 8'h68, 8'h00, sm1);
        join
        idle(5);
        chk("post-reset w8 words drained", 32'(q0.size()), 32'd0);
        chk("post-reset w2 words drained", 32'(q1.size()), 32'd0);
        chk("post-reset frozen_err", 32'(frozen_err[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
